approx_add_err_sweep: RTL and testbench

- Sequencer that drives a combinational approximate ripple-carry adder under test with an exhaustive operand sweep.
- Compares each adder result against the exact sum and accumulates error statistics: mismatch count, sum of absolute errors, maximum absolute error.
- Sits beside the 16-bit approximate adders as the on-chip/bench characterisation engine for error metrics (MAE, error rate, worst case).
- One sample per clock; adder is external; block owns operand sequencing and statistics.

---
 rtl/approx_add_err_sweep.sv | 122 ++++++++++++
 tb/tb_approx_add_err_sweep.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/approx_add_err_sweep.sv
// rtl/approx_add_err_sweep.sv - exhaustive operand sweep and error statistics for an approximate adder
// Optional worst-case operand capture: APPROX_SWEEP_WORST_CAPTURE_EN
module approx_add_err_sweep #(
  parameter int W          = 16,
  parameter int SWEEP_BITS = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [W-1:0]            op_a,
  output logic [W-1:0]            op_b,
  input  logic [W:0]              sum_in,
  output logic                    busy,
  output logic                    done,
  output logic [SWEEP_BITS:0]     n_samples,
  output logic [SWEEP_BITS:0]     err_cnt,
  output logic [W+SWEEP_BITS:0]   err_sum,
  output logic [W:0]              max_err
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
  ,
  output logic [W-1:0]            worst_a,
  output logic [W-1:0]            worst_b
`endif
);

  localparam int H  = SWEEP_BITS / 2;
  localparam int NW = SWEEP_BITS + 1;
  localparam int SW = W + 1 + SWEEP_BITS;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nx;
  logic [SWEEP_BITS-1:0] cnt, cnt_nx;
  logic [W:0]            exact, err_d, err_q;
  logic                  valid;
  logic                  start_ok;
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
  logic [W-1:0]          opa_q, opb_q;
`endif

  assign start_ok = start && (state == IDLE || state == DONE);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // Counter saturates at its maximum; the sweep ends there anyway.
  assign cnt_nx = (&cnt) ? cnt : cnt + SWEEP_BITS'(1);
  assign exact  = {1'b0, op_a} + {1'b0, op_b};
  // |sum_in - exact| without needing a wider signed intermediate.
  assign err_d  = (sum_in >= exact) ? (sum_in - exact) : (exact - sum_in);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (abort || (&cnt)) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      err_q     <= '0;
      valid     <= 1'b0;
      n_samples <= '0;
      err_cnt   <= '0;
      err_sum   <= '0;
      max_err   <= '0;
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
      opa_q     <= '0;
      opb_q     <= '0;
      worst_a   <= '0;
      worst_b   <= '0;
`endif
    end else begin
      state <= state_nx;
      valid <= (state == RUN);
      if (state == RUN) begin
        err_q <= err_d;
        cnt   <= cnt_nx;
        op_a  <= W'(cnt_nx[H-1:0]);
        op_b  <= W'(cnt_nx[SWEEP_BITS-1:H]);
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
        opa_q <= op_a;
        opb_q <= op_b;
`endif
      end
      // valid is never set in IDLE/DONE, so a clear cannot collide with an accumulate.
      if (start_ok) begin
        cnt       <= '0;
        op_a      <= '0;
        op_b      <= '0;
        n_samples <= '0;
        err_cnt   <= '0;
        err_sum   <= '0;
        max_err   <= '0;
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
        worst_a   <= '0;
        worst_b   <= '0;
`endif
      end else if (valid) begin
        n_samples <= n_samples + NW'(1);
        err_cnt   <= err_cnt + NW'(err_q != '0);
        err_sum   <= err_sum + SW'(err_q);
        if (err_q > max_err) begin
          max_err <= err_q;
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
          worst_a <= opa_q;
          worst_b <= opb_q;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_add_err_sweep.sv
// tb/tb_approx_add_err_sweep.sv - table-driven scoreboard bench for approx_add_err_sweep (W=4, SWEEP_BITS=8)
// Optional worst-case operand checks: APPROX_SWEEP_WORST_CAPTURE_EN
module tb_approx_add_err_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  op_a, op_b;
  logic [4:0]  sum_in;
  logic        busy, done;
  logic [8:0]  n_samples, err_cnt;
  logic [12:0] err_sum;
  logic [4:0]  max_err;
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
  logic [3:0]  worst_a, worst_b;
`endif

  int mode = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  approx_add_err_sweep #(.W(4), .SWEEP_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .sum_in(sum_in),
    .busy(busy), .done(done),
    .n_samples(n_samples), .err_cnt(err_cnt), .err_sum(err_sum), .max_err(max_err)
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
    , .worst_a(worst_a), .worst_b(worst_b)
`endif
  );

  // Adder models: 0 exact, 1 off-by-one, 2 single fault (+7 at 3,5), 3 LSB dropped, 4 carry-out dropped
  function automatic int adder(input int m, input int a, input int b);
    case (m)
      1:       return (a + b + 1) & 31;
      2:       return (a == 3 && b == 5) ? a + b + 7 : a + b;
      3:       return (a + b) & 30;
      4:       return (a + b) & 15;
      default: return a + b;
    endcase
  endfunction

  always_comb sum_in = 5'(adder(mode, int'(op_a), int'(op_b)));

  typedef struct {
    int mode;
    int abort_at;    // RUN cycle carrying abort, 0 = full sweep
    bit drain_start; // pulse start during DRAIN
  } vec_t;

  typedef struct {
    int n, cnt, sum, mx, wa, wb, done_cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int m, input int nlim);
    exp_t e;
    e = '{default: 0};
    for (int i = 0; i < nlim; i++) begin
      int a, b, d;
      a = i & 15;
      b = i >> 4;
      d = adder(m, a, b) - (a + b);
      if (d < 0) d = -d;
      e.n++;
      if (d != 0) e.cnt++;
      e.sum += d;
      if (d > e.mx) begin
        e.mx = d;
        e.wa = a;
        e.wb = b;
      end
    end
    e.done_cyc = nlim + 2;
    return e;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e, g;
    int nlim, cyc;
    nlim = (v.abort_at == 0) ? 256 : v.abort_at;
    sbq.push_back(model(v.mode, nlim));
    mode  = v.mode;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    abort = (cyc == v.abort_at);
    chk("busy_in_run", busy, 1);
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      abort = (cyc == v.abort_at);
      start = v.drain_start && (cyc == nlim + 1);
    end
    abort = 1'b0;
    start = 1'b0;
    chk("done_seen", done, 1);
    repeat (3) @(posedge clk);
    #1;
    e = sbq.pop_front();
    g = e;
    chk("done_cycle", cyc, e.done_cyc);
    chk("done_hold", done, 1);
    chk("n_samples", n_samples, e.n);
    chk("err_cnt", err_cnt, e.cnt);
    chk("err_sum", err_sum, e.sum);
    chk("max_err", max_err, e.mx);
`ifdef APPROX_SWEEP_WORST_CAPTURE_EN
    chk("worst_a", worst_a, g.wa);
    chk("worst_b", worst_b, g.wb);
`endif
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 0, 0};
    vecs[1] = '{1, 0, 0};
    vecs[2] = '{2, 0, 0};
    vecs[3] = '{3, 0, 0};
    vecs[4] = '{4, 0, 0};
    vecs[5] = '{1, 10, 1};
    vecs[6] = '{1, 0, 0};
    vecs[7] = '{4, 1, 0};
    vecs[8] = '{1, 256, 0};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_n_samples", n_samples, 0);
    chk("rst_ops", {op_a, op_b}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a sweep with nonzero statistics.
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("pre_rst_err_cnt_nonzero", err_cnt != 0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_n_samples", n_samples, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    chk("async_rst_err_sum", err_sum, 0);
    chk("async_rst_max_err", max_err, 0);
    chk("async_rst_ops", {op_a, op_b}, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst", busy, 0);
    run_vec(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
